// File: rtl/lfsr_checker.sv
// Receive-side checker for the 32-bit PRBS word generator (taps 31/30/26/25).
// Self-synchronises to the incoming word stream, declares lock and counts mismatches.
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             pulse,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      checked_count,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  // Run counters only need to reach COUNT-1; the next hit/miss completes the run.
  localparam int MR_W = (LOCK_COUNT < 3) ? 1 : $clog2(LOCK_COUNT);
  localparam int MS_W = (LOSS_COUNT < 3) ? 1 : $clog2(LOSS_COUNT);
  localparam logic [MR_W-1:0] LOCK_LAST = MR_W'(LOCK_COUNT - 1);
  localparam logic [MS_W-1:0] LOSS_LAST = MS_W'(LOSS_COUNT - 1);

  logic [31:0]     prev;
  logic [31:0]     expected;
  logic [MR_W-1:0] match_run;
  logic [MS_W-1:0] miss_run;
  logic            hit;

  assign expected = {prev[30:0], prev[31] ^ prev[30] ^ prev[26] ^ prev[25]};
  // The all-zero lockup word can never count as a match.
  assign hit = (in_data == expected) && (in_data != 32'd0);

  always_ff @(posedge pulse) begin
    if (rst) begin
      state         <= IDLE;
      locked        <= 1'b0;
      mismatch      <= 1'b0;
      err_count     <= '0;
      checked_count <= '0;
      prev          <= '0;
      match_run     <= '0;
      miss_run      <= '0;
    end else begin
      mismatch <= 1'b0;
      if (in_valid) begin
        case (state)
          IDLE: begin
            if (in_data != 32'd0) begin
              prev      <= in_data;
              match_run <= '0;
              state     <= SEARCH;
            end
          end
          SEARCH: begin
            prev <= in_data;
            if (hit) begin
              if (match_run == LOCK_LAST) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                miss_run  <= '0;
                match_run <= '0;
              end else begin
                match_run <= match_run + MR_W'(1);
              end
            end else begin
              match_run <= '0;
            end
          end
          LOCKED: begin
            if (checked_count != '1) checked_count <= checked_count + 32'd1;
            if (hit) begin
              prev     <= in_data;
              miss_run <= '0;
            end else begin
              mismatch <= 1'b1;
              if (err_count != '1) err_count <= err_count + ERR_W'(1);
              // Flywheel on the prediction so one bad word costs one error.
              if (miss_run == LOSS_LAST) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                match_run <= '0;
                miss_run  <= '0;
                prev      <= in_data;
              end else begin
                miss_run <= miss_run + MS_W'(1);
                prev     <= expected;
              end
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
      if (clr_err) begin
        err_count     <= '0;
        checked_count <= '0;
      end
    end
  end

endmodule
